rv_commit_trace: RTL and testbench

- Synthesizable retirement-trace capture unit for the rv32 single-cycle core and its successors.
- Sits beside the datapath and samples one retired instruction per cycle: PC, instruction word, and register write-back.
- Buffers records in a parametrised circular FIFO and drains them over a valid/ready port.
- Tracks cycle count, detects halt (self-loop jump) and watchdog timeout, so benches and on-chip debug need not probe datapath internals.

---
 rtl/rv_commit_trace_if.sv | 67 ++++++
 rtl/rv_commit_trace.sv | 132 +++++++++++++
 tb/tb_rv_commit_trace.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_commit_trace_if.sv
// Retire-side and trace-side signal bundle for rv_commit_trace.
// Memory-access fields exist only when RV_TRACE_MEM_EN is defined.
interface rv_commit_trace_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             ret_valid;
  logic [XLEN-1:0]  ret_pc;
  logic [31:0]      ret_instr;
  logic             ret_rd_we;
  logic [4:0]       ret_rd_addr;
  logic [XLEN-1:0]  ret_rd_data;

  logic             tr_valid;
  logic             tr_ready;
  logic [XLEN-1:0]  tr_pc;
  logic [31:0]      tr_instr;
  logic             tr_rd_we;
  logic [4:0]       tr_rd_addr;
  logic [XLEN-1:0]  tr_rd_data;
  logic [CYC_W-1:0] tr_cycle;

  logic [CNT_W-1:0] count;
  logic [CYC_W-1:0] dropped;
  logic [CYC_W-1:0] cycle_cnt;
  logic [CYC_W-1:0] retired_cnt;
  logic             halted;
  logic             timeout;

`ifdef RV_TRACE_MEM_EN
  logic             ret_mem_we;
  logic [XLEN-1:0]  ret_mem_addr;
  logic [XLEN-1:0]  ret_mem_wdata;
  logic             tr_mem_we;
  logic [XLEN-1:0]  tr_mem_addr;
  logic [XLEN-1:0]  tr_mem_wdata;

  modport master (
    output ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd_addr, ret_rd_data,
           ret_mem_we, ret_mem_addr, ret_mem_wdata, tr_ready,
    input  tr_valid, tr_pc, tr_instr, tr_rd_we, tr_rd_addr, tr_rd_data, tr_cycle,
           tr_mem_we, tr_mem_addr, tr_mem_wdata,
           count, dropped, cycle_cnt, retired_cnt, halted, timeout
  );
  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd_addr, ret_rd_data,
           ret_mem_we, ret_mem_addr, ret_mem_wdata, tr_ready,
    output tr_valid, tr_pc, tr_instr, tr_rd_we, tr_rd_addr, tr_rd_data, tr_cycle,
           tr_mem_we, tr_mem_addr, tr_mem_wdata,
           count, dropped, cycle_cnt, retired_cnt, halted, timeout
  );
`else
  modport master (
    output ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd_addr, ret_rd_data, tr_ready,
    input  tr_valid, tr_pc, tr_instr, tr_rd_we, tr_rd_addr, tr_rd_data, tr_cycle,
           count, dropped, cycle_cnt, retired_cnt, halted, timeout
  );
  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd_addr, ret_rd_data, tr_ready,
    output tr_valid, tr_pc, tr_instr, tr_rd_we, tr_rd_addr, tr_rd_data, tr_cycle,
           count, dropped, cycle_cnt, retired_cnt, halted, timeout
  );
`endif
endinterface

// File: rtl/rv_commit_trace.sv
// Retirement-trace capture: circular FIFO of retired-instruction records with halt and
// watchdog detection. Define RV_TRACE_MEM_EN to also record store address/data per entry.
module rv_commit_trace #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 32,
  parameter int MAX_CYCLES = 150,
  parameter int OVERWRITE  = 0
) (
  input logic           clk,
  input logic           rst_n,
  rv_commit_trace_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [31:0]      HALT_INSTR = 32'h0000_006F;
  localparam bit               WD_EN      = (MAX_CYCLES != 0);
  localparam logic [CYC_W-1:0] WD_LIMIT   = CYC_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);
  localparam logic [AW:0]      PTR_ONE    = (AW + 1)'(1);

  typedef enum logic [1:0] {RUN, HALT, TOUT} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic             we_mem    [DEPTH];
  logic [4:0]       addr_mem  [DEPTH];
  logic [XLEN-1:0]  data_mem  [DEPTH];
  logic [CYC_W-1:0] cyc_mem   [DEPTH];
`ifdef RV_TRACE_MEM_EN
  logic             mwe_mem   [DEPTH];
  logic [XLEN-1:0]  maddr_mem [DEPTH];
  logic [XLEN-1:0]  mdata_mem [DEPTH];
`endif

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [CNT_W-1:0] occ;
  logic [CYC_W-1:0] cycle_cnt, retired_cnt, dropped;
  logic             empty, full, push, pop, wr_en, rd_adv, drop_evt;
  logic             halt_hit, tout_hit, rd_we_m;
  logic [XLEN-1:0]  rd_data_m;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign occ    = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (occ == CNT_W'(DEPTH));

  assign push     = bus.ret_valid && (state == RUN);
  assign pop      = !empty && bus.tr_ready;
  assign halt_hit = push && (bus.ret_instr == HALT_INSTR);
  assign tout_hit = WD_EN && (cycle_cnt == WD_LIMIT);

  // A pop in the same cycle frees the slot, so only a full FIFO without a pop loses a record.
  assign drop_evt = push && full && !pop;
  assign wr_en    = push && (!full || pop || (OVERWRITE != 0));
  assign rd_adv   = pop || (drop_evt && (OVERWRITE != 0));

  // x0 is hardwired to zero, so a write to it is recorded as no write at all.
  assign rd_we_m   = bus.ret_rd_we && (bus.ret_rd_addr != 5'd0);
  assign rd_data_m = rd_we_m ? bus.ret_rd_data : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (halt_hit) state_nxt = HALT;
               else if (tout_hit) state_nxt = TOUT;
      default: state_nxt = state;
    endcase
  end

  // The counter holds on the edge that leaves RUN, so it ends on the halting/expiry cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      dropped     <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en)    wr_ptr      <= wr_ptr + PTR_ONE;
      if (rd_adv)   rd_ptr      <= rd_ptr + PTR_ONE;
      if (push)     retired_cnt <= sat_inc(retired_cnt);
      if (drop_evt) dropped     <= sat_inc(dropped);
      if (state == RUN && state_nxt == RUN) cycle_cnt <= sat_inc(cycle_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx]    <= bus.ret_pc;
      instr_mem[wr_idx] <= bus.ret_instr;
      we_mem[wr_idx]    <= rd_we_m;
      addr_mem[wr_idx]  <= bus.ret_rd_addr;
      data_mem[wr_idx]  <= rd_data_m;
      cyc_mem[wr_idx]   <= cycle_cnt;
`ifdef RV_TRACE_MEM_EN
      mwe_mem[wr_idx]   <= bus.ret_mem_we;
      maddr_mem[wr_idx] <= bus.ret_mem_addr;
      mdata_mem[wr_idx] <= bus.ret_mem_wdata;
`endif
    end
  end

  // Head fields are gated to zero while empty so reset shows all-zero trace outputs.
  assign bus.tr_valid    = !empty;
  assign bus.tr_pc       = empty ? '0 : pc_mem[rd_idx];
  assign bus.tr_instr    = empty ? '0 : instr_mem[rd_idx];
  assign bus.tr_rd_we    = empty ? 1'b0 : we_mem[rd_idx];
  assign bus.tr_rd_addr  = empty ? '0 : addr_mem[rd_idx];
  assign bus.tr_rd_data  = empty ? '0 : data_mem[rd_idx];
  assign bus.tr_cycle    = empty ? '0 : cyc_mem[rd_idx];
`ifdef RV_TRACE_MEM_EN
  assign bus.tr_mem_we    = empty ? 1'b0 : mwe_mem[rd_idx];
  assign bus.tr_mem_addr  = empty ? '0 : maddr_mem[rd_idx];
  assign bus.tr_mem_wdata = empty ? '0 : mdata_mem[rd_idx];
`endif

  assign bus.count       = occ;
  assign bus.dropped     = dropped;
  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.retired_cnt = retired_cnt;
  assign bus.halted      = (state == HALT);
  assign bus.timeout     = (state == TOUT);
endmodule

// File: tb/tb_rv_commit_trace.sv
// Directed bench for rv_commit_trace: drop/overwrite instances share stimulus, a third
// instance exercises the watchdog; records are checked against per-instance scoreboards.
module tb_rv_commit_trace;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n2;
  logic        rv, rdy, we;
  logic [31:0] pc, instr, data;
  logic [4:0]  addr;

  rv_commit_trace_if #(.XLEN(32), .DEPTH(4),  .CYC_W(32)) bus0 ();
  rv_commit_trace_if #(.XLEN(32), .DEPTH(4),  .CYC_W(32)) bus1 ();
  rv_commit_trace_if #(.XLEN(32), .DEPTH(16), .CYC_W(32)) bus2 ();

  assign bus0.ret_valid = rv;  assign bus1.ret_valid = rv;  assign bus2.ret_valid = 1'b0;
  assign bus0.ret_pc = pc;     assign bus1.ret_pc = pc;     assign bus2.ret_pc = '0;
  assign bus0.ret_instr = instr; assign bus1.ret_instr = instr; assign bus2.ret_instr = '0;
  assign bus0.ret_rd_we = we;  assign bus1.ret_rd_we = we;  assign bus2.ret_rd_we = 1'b0;
  assign bus0.ret_rd_addr = addr; assign bus1.ret_rd_addr = addr; assign bus2.ret_rd_addr = '0;
  assign bus0.ret_rd_data = data; assign bus1.ret_rd_data = data; assign bus2.ret_rd_data = '0;
  assign bus0.tr_ready = rdy;  assign bus1.tr_ready = rdy;  assign bus2.tr_ready = 1'b1;
`ifdef RV_TRACE_MEM_EN
  assign bus0.ret_mem_we = 1'b0; assign bus1.ret_mem_we = 1'b0; assign bus2.ret_mem_we = 1'b0;
  assign bus0.ret_mem_addr = '0; assign bus1.ret_mem_addr = '0; assign bus2.ret_mem_addr = '0;
  assign bus0.ret_mem_wdata = '0; assign bus1.ret_mem_wdata = '0; assign bus2.ret_mem_wdata = '0;
`endif

  rv_commit_trace #(.DEPTH(4), .OVERWRITE(0)) u0 (.clk(clk), .rst_n(rst_n),  .bus(bus0));
  rv_commit_trace #(.DEPTH(4), .OVERWRITE(1)) u1 (.clk(clk), .rst_n(rst_n),  .bus(bus1));
  rv_commit_trace #(.DEPTH(16), .MAX_CYCLES(10)) u2 (.clk(clk), .rst_n(rst_n2), .bus(bus2));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] cyc;
  } rec_t;

  rec_t q0[$], q1[$];
  int   checks = 0, errors = 0;
  int   edge_n;
  int   ret_m;
  bit   run_m;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t obs0();
    rec_t r;
    r.pc = bus0.tr_pc; r.instr = bus0.tr_instr; r.rd_we = bus0.tr_rd_we;
    r.rd_addr = bus0.tr_rd_addr; r.rd_data = bus0.tr_rd_data; r.cyc = bus0.tr_cycle;
    return r;
  endfunction

  function automatic rec_t obs1();
    rec_t r;
    r.pc = bus1.tr_pc; r.instr = bus1.tr_instr; r.rd_we = bus1.tr_rd_we;
    r.rd_addr = bus1.tr_rd_addr; r.rd_data = bus1.tr_rd_data; r.cyc = bus1.tr_cycle;
    return r;
  endfunction

  // Called just after a falling edge: drive inputs, score the pop that the coming rising
  // edge performs, push the expected record, then advance to the next falling edge.
  task automatic step(input bit v, input logic [31:0] p, input logic [31:0] ins,
                      input bit w, input logic [4:0] a, input logic [31:0] d, input bit r);
    rec_t e;
    rv = v; pc = p; instr = ins; we = w; addr = a; data = d; rdy = r;
    if (r && bus0.tr_valid) begin
      if (q0.size() > 0) chk("u0 record", obs0(), q0.pop_front());
      else               chk("u0 spurious valid", bus0.tr_valid, 1'b0);
    end
    if (r && bus1.tr_valid) begin
      if (q1.size() > 0) chk("u1 record", obs1(), q1.pop_front());
      else               chk("u1 spurious valid", bus1.tr_valid, 1'b0);
    end
    if (v && run_m) begin
      e.pc = p; e.instr = ins; e.rd_we = w && (a != 5'd0); e.rd_addr = a;
      e.rd_data = e.rd_we ? d : 32'd0; e.cyc = edge_n;
      ret_m++;
      if (q0.size() < 4) q0.push_back(e);
      if (q1.size() >= 4) void'(q1.pop_front());
      q1.push_back(e);
      if (ins == 32'h0000_006F) run_m = 1'b0;
    end
    @(negedge clk);
    rv = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      step(0, 0, 0, 0, 0, 0, 1);
      n++;
    end
    chk("drain left u0", q0.size(), 0);
    chk("drain left u1", q1.size(), 0);
    chk("drain count u0", bus0.count, 0);
    chk("drain count u1", bus1.count, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rv = 1'b0; rdy = 1'b0;
    pc = '0; instr = '0; we = 1'b0; addr = '0; data = '0;
    q0.delete(); q1.delete();
    ret_m = 0; run_m = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n2 = 1'b0;
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst tr_valid", bus0.tr_valid, 1'b0);
    chk("rst count", bus0.count, 0);
    chk("rst halted", bus0.halted, 1'b0);
    chk("rst timeout", bus0.timeout, 1'b0);
    chk("rst cycle_cnt", bus0.cycle_cnt, 0);
    chk("rst retired_cnt", bus0.retired_cnt, 0);
    chk("rst dropped", bus0.dropped, 0);
    chk("rst tr_pc", bus0.tr_pc, 0);
    chk("rst tr_cycle", bus0.tr_cycle, 0);
    chk("rst u2 timeout", bus2.timeout, 1'b0);

    // Capture and drain: addi x1,x0,5 then addi x2,x1,3.
    do_reset();
    step(1, 32'h0, 32'h0050_0093, 1, 5'd1, 32'd5, 1);
    chk("push on empty count", bus0.count, 1);
    step(1, 32'h4, 32'h0030_8113, 1, 5'd2, 32'd8, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("retired_cnt 2", bus0.retired_cnt, 2);
    chk("retired model", bus0.retired_cnt, ret_m);
    drain();

    // x0 write is recorded as no write.
    step(1, 32'h8, 32'h0DE0_0013, 1, 5'd0, 32'hDEAD, 0);
    chk("x0 tr_valid", bus0.tr_valid, 1'b1);
    chk("x0 tr_rd_we", bus0.tr_rd_we, 1'b0);
    chk("x0 tr_rd_data", bus0.tr_rd_data, 0);
    drain();

    // Full FIFO: six records with the consumer stalled.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 32'(i * 4), 32'h0011_8193, 1, 5'd3, 32'(i), 0);
    chk("drop count", bus0.count, 4);
    chk("drop dropped", bus0.dropped, 2);
    chk("ovw count", bus1.count, 4);
    chk("ovw dropped", bus1.dropped, 2);
    chk("drop head pc", bus0.tr_pc, 32'h0);
    chk("ovw head pc", bus1.tr_pc, 32'h8);
    // Push and pop together while full: nothing lost, occupancy unchanged.
    step(1, 32'd24, 32'h0011_8193, 1, 5'd3, 32'd6, 1);
    chk("full push+pop count", bus0.count, 4);
    chk("full push+pop dropped", bus0.dropped, 2);
    chk("full push+pop ovw dropped", bus1.dropped, 2);
    drain();

    // Halt on jal x0,0 with retirements continuing afterwards.
    do_reset();
    step(1, 32'h3C, 32'h0011_8193, 1, 5'd3, 32'd1, 0);
    step(1, 32'h40, 32'h0000_006F, 0, 5'd0, 32'd0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 32'(32'h44 + i * 4), 32'h0011_8193, 1, 5'd3, 32'd2, 0);
    chk("halt halted", bus0.halted, 1'b1);
    chk("halt timeout", bus0.timeout, 1'b0);
    chk("halt count", bus0.count, 2);
    chk("halt retired", bus0.retired_cnt, 2);
    chk("halt cycle_cnt", bus0.cycle_cnt, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("halt cycle frozen", bus0.cycle_cnt, 1);
    chk("halt head valid", bus0.tr_valid, 1'b1);
    chk("halt head pc", bus0.tr_pc, 32'h40);
    chk("halt head cyc", bus0.tr_cycle, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst tr_valid", bus0.tr_valid, 1'b0);
    chk("midrst count", bus0.count, 0);
    chk("midrst halted", bus0.halted, 1'b0);
    do_reset();

    // Watchdog on the MAX_CYCLES=10 instance.
    @(negedge clk);
    rst_n2 = 1'b1;
    repeat (9) @(negedge clk);
    chk("wd before timeout", bus2.timeout, 1'b0);
    chk("wd before cycle_cnt", bus2.cycle_cnt, 9);
    @(negedge clk);
    chk("wd timeout", bus2.timeout, 1'b1);
    chk("wd cycle_cnt", bus2.cycle_cnt, 9);
    chk("wd halted", bus2.halted, 1'b0);
    repeat (3) @(negedge clk);
    chk("wd timeout held", bus2.timeout, 1'b1);
    chk("wd cycle_cnt held", bus2.cycle_cnt, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
